// File: rtl/pc.sv
// Program counter register for the single-cycle RV32I core.
// Loads the next-PC value on every rising clk edge. The low alignment bits
// are forced to zero, and rst returns the counter to RESET_VECTOR.
// There is no enable input: the datapath advances every cycle.
module pc #(
   parameter int                 WIDTH        = 32,
   parameter logic [WIDTH-1:0]   RESET_VECTOR = 32'h0000_0000,
   parameter int                 ALIGN_BITS   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  PC_next,
   output logic [WIDTH-1:0]  PC_out
);

   // Ones above the alignment field. With ALIGN_BITS = 0 this is all ones,
   // so nothing is masked.
   localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN_BITS;

   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] pc_q;

   // Next-state value: PC_next with its misaligned low bits dropped.
   always_comb begin
      pc_d = PC_next & ALIGN_MASK;
   end

   // PC register. The asynchronous reset wins over any clock edge.
   // While rst is high, PC_next, including X, never reaches the flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign PC_out = pc_q;

`ifndef SYNTHESIS
   // A reset vector off a 4-byte boundary could never be fetched.
   if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
      $error("pc: RESET_VECTOR %h is not 4-byte aligned", RESET_VECTOR);
   end

   // Flag loads that discard nonzero low bits.
   // Masking is legal; a misaligned target usually means an upstream bug.
   if (ALIGN_BITS > 0) begin : g_align_warn
      always @(posedge clk) begin
         if (!rst && (|(PC_next & ~ALIGN_MASK))) begin
            $warning("pc: misaligned PC_next %h masked to %h", PC_next, pc_d);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pc.sv
// Directed bench for the program counter register.
// Every expected PC comes from a small reference model and is queued when
// stimulus is applied. It is popped and compared when the DUT output
// should show it.
module tb_pc;

   localparam int          WIDTH = 32;
   localparam logic [31:0] RV    = 32'h0000_0000;
   localparam logic [31:0] MASK  = 32'hFFFF_FFFC;

   logic              clk;
   logic              rst;
   logic [WIDTH-1:0]  PC_next;
   logic [WIDTH-1:0]  PC_out;

   logic [31:0] exp_q[$];
   logic [31:0] model_pc;
   int          tests;
   int          fails;

   pc #(
      .WIDTH        (WIDTH),
      .RESET_VECTOR (RV),
      .ALIGN_BITS   (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .PC_next (PC_next),
      .PC_out  (PC_out)
   );

   task automatic expect_now();
      exp_q.push_back(model_pc);
   endtask

   task automatic check(input string tag);
      logic [31:0] exp;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $error("FAIL %s: scoreboard empty, PC_out=%h", tag, PC_out);
      end else begin
         exp = exp_q.pop_front();
         assert (PC_out === exp) else begin
            fails++;
            $error("FAIL %s: PC_out=%h expected %h", tag, PC_out, exp);
         end
      end
   endtask

   // One full clock cycle with clk starting low.
   // The PC is checked before the edge, where it must hold its value,
   // and again 1 ns after the edge.
   task automatic step(input logic [31:0] nxt, input string tag);
      PC_next = nxt;
      #1;
      expect_now();
      check({tag, "_hold"});
      model_pc = rst ? RV : (nxt & MASK);
      expect_now();
      #4 clk = 1'b1;
      #1 check(tag);
      #4 clk = 1'b0;
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      clk      = 1'b0;
      rst      = 1'b0;
      PC_next  = 32'h1234_5678;
      model_pc = RV;

      // Async reset with the clock stopped low.
      #3 rst = 1'b1;
      #1;
      expect_now();
      check("async_reset");

      // Reset holds across edges, and an X on PC_next must not leak through.
      step(32'h1234_5678, "rst_hold0");
      step('x,            "rst_hold_x");
      step(32'hDEAD_BEEC, "rst_hold2");

      // Release between edges; the first edge loads PC_next.
      #2 rst = 1'b0;
      #1;
      expect_now();
      check("release_no_edge");
      for (int i = 0; i < 4; i++) begin
         step(model_pc + 32'd4, $sformatf("seq%0d", i));
      end

      // Branch and jump targets.
      step(32'h0000_0100, "branch_100");
      step(32'h0000_0040, "branch_40");

      // Misaligned targets are masked.
      step(32'h0000_0207, "align_207");
      step(32'h0000_0003, "align_003");

      // Wrap-around.
      step(32'hFFFF_FFFC, "wrap_top");
      step(32'h0000_0000, "wrap_zero");

      // Mid-run reset two ns after a rising edge, released before the next edge.
      step(32'h0000_0100, "pre_rst_100");
      PC_next = 32'h0000_0200;
      clk = 1'b1;
      #2 rst = 1'b1;
      model_pc = RV;
      #1;
      expect_now();
      check("midrun_reset");
      #2 clk = 1'b0;
      #2 rst = 1'b0;
      #1;
      expect_now();
      check("midrun_release");
      #2;
      step(32'h0000_0004, "after_midrun");

      // Reset pulse entirely within one clk-high phase.
      step(32'h0000_0300, "pre_pulse");
      PC_next = 32'h0000_0500;
      clk = 1'b1;
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      model_pc = RV;
      #1;
      expect_now();
      check("pulse_high_phase");
      #2 clk = 1'b0;
      #1;
      expect_now();
      check("pulse_clk_low");
      #4;
      step(32'h0000_0008, "after_pulse");

      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
